yuv_to_rgb_seq: RTL and testbench

//  Multi-cycle YUV->RGB converter, the inverse of the team's RGB->YUV datapath+controller.
//  One shared signed multiplier, sequenced by an internal FSM; start/done handshake.

---
 rtl/yuv_to_rgb_seq.sv | 151 +++++++++++++++
 tb/tb_yuv_to_rgb_seq.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/yuv_to_rgb_seq.sv
// Multi-cycle YUV->RGB converter: one shared signed multiplier sequenced by a
// six-state FSM. Each chroma term is rounded on its own, then summed into
// per-channel accumulators and saturated to YW bits in the final state.
module yuv_to_rgb_seq #(
  parameter int YW   = 8,
  parameter int CW   = 9,
  parameter int FRAC = 8,
  parameter int C_RV = 359,
  parameter int C_GU = 88,
  parameter int C_GV = 183,
  parameter int C_BU = 454
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [YW-1:0] y_in,
  input  logic [CW-1:0] u_in,
  input  logic [CW-1:0] v_in,
  output logic          busy,
  output logic          done,
  output logic [YW-1:0] r_out,
  output logic [YW-1:0] g_out,
  output logic [YW-1:0] b_out
);

  localparam int KW = 12;        // signed coefficient width
  localparam int PW = CW + 12;   // product width, headroom for the rounding add
  localparam int AW = 12;        // accumulator width

  localparam logic signed [KW-1:0] K_RV = KW'(C_RV);
  localparam logic signed [KW-1:0] K_GU = KW'(C_GU);
  localparam logic signed [KW-1:0] K_GV = KW'(C_GV);
  localparam logic signed [KW-1:0] K_BU = KW'(C_BU);
  localparam logic signed [PW-1:0] RND  = PW'(2 ** (FRAC - 1));
  localparam logic signed [AW-1:0] MAXV = AW'((2 ** YW) - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    M_RV = 3'd1,
    M_GU = 3'd2,
    M_GV = 3'd3,
    M_BU = 3'd4,
    SAT  = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic [YW-1:0]         y_q, y_d;
  logic [CW-1:0]         u_q, u_d, v_q, v_d;
  logic signed [AW-1:0]  acc_r_q, acc_r_d, acc_g_q, acc_g_d, acc_b_q, acc_b_d;
  logic [YW-1:0]         r_q, r_d, g_q, g_d, b_q, b_d;
  logic                  done_q, done_d;

  logic signed [CW-1:0]  mul_x;
  logic signed [KW-1:0]  mul_c;
  logic signed [PW-1:0]  prod_rnd;
  logic signed [AW-1:0]  term;
  logic signed [AW-1:0]  y_ext;

  function automatic logic [YW-1:0] sat(input logic signed [AW-1:0] a);
    if (a[AW-1])      sat = '0;
    else if (a > MAXV) sat = '1;
    else              sat = a[YW-1:0];
  endfunction

  // Operand/coefficient select for the shared multiplier, then round and floor-shift.
  always_comb begin
    mul_x = $signed(u_q);
    mul_c = K_GU;
    case (state_q)
      M_RV:    begin mul_x = $signed(v_q); mul_c = K_RV; end
      M_GU:    begin mul_x = $signed(u_q); mul_c = K_GU; end
      M_GV:    begin mul_x = $signed(v_q); mul_c = K_GV; end
      M_BU:    begin mul_x = $signed(u_q); mul_c = K_BU; end
      default: ;
    endcase
    prod_rnd = PW'(mul_x) * PW'(mul_c) + RND;
    term     = AW'(prod_rnd >>> FRAC);
    y_ext    = $signed({{(AW-YW){1'b0}}, y_q});
  end

  // Next-state, operand capture, accumulation and saturation.
  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    u_d     = u_q;
    v_d     = v_q;
    acc_r_d = acc_r_q;
    acc_g_d = acc_g_q;
    acc_b_d = acc_b_q;
    r_d     = r_q;
    g_d     = g_q;
    b_d     = b_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d = M_RV;
        y_d     = y_in;
        u_d     = u_in;
        v_d     = v_in;
      end
      M_RV: begin acc_r_d = y_ext + term;   state_d = M_GU; end
      M_GU: begin acc_g_d = y_ext - term;   state_d = M_GV; end
      M_GV: begin acc_g_d = acc_g_q - term; state_d = M_BU; end
      M_BU: begin acc_b_d = y_ext + term;   state_d = SAT;  end
      SAT: begin
        r_d     = sat(acc_r_q);
        g_d     = sat(acc_g_q);
        b_d     = sat(acc_b_q);
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, operand, accumulator and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      y_q     <= '0;
      u_q     <= '0;
      v_q     <= '0;
      acc_r_q <= '0;
      acc_g_q <= '0;
      acc_b_q <= '0;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      u_q     <= u_d;
      v_q     <= v_d;
      acc_r_q <= acc_r_d;
      acc_g_q <= acc_g_d;
      acc_b_q <= acc_b_d;
      r_q     <= r_d;
      g_q     <= g_d;
      b_q     <= b_d;
      done_q  <= done_d;
    end
  end

  assign busy  = (state_q != IDLE);
  assign done  = done_q;
  assign r_out = r_q;
  assign g_out = g_q;
  assign b_out = b_q;

endmodule

// File: tb/tb_yuv_to_rgb_seq.sv
// Bench for yuv_to_rgb_seq: a pixel-level model (5 busy cycles, then a done
// pulse carrying floor-rounded, clamped RGB) checked every cycle, plus
// directed vectors with hand-computed literal results.
module tb_yuv_to_rgb_seq;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] y_in = '0;
  logic [8:0] u_in = '0;
  logic [8:0] v_in = '0;
  logic       busy, done;
  logic [7:0] r_out, g_out, b_out;

  int errs = 0;
  int checks = 0;

  yuv_to_rgb_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .y_in(y_in), .u_in(u_in), .v_in(v_in),
    .busy(busy), .done(done),
    .r_out(r_out), .g_out(g_out), .b_out(b_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Rounded term: floor((x*c + 128) / 256) done with true division.
  function automatic int term(input int x, input int c);
    int p, q;
    p = x * c + 128;
    q = p / 256;
    if (p < 0 && q * 256 != p) q = q - 1;
    return q;
  endfunction

  function automatic int clamp(input int a);
    return (a < 0) ? 0 : (a > 255) ? 255 : a;
  endfunction

  // Pixel-level model: a conversion occupies five busy cycles, then RGB lands with done.
  int m_cnt, m_y, m_u, m_v, m_r, m_g, m_b;
  logic m_done;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt <= 0; m_done <= 1'b0; m_r <= 0; m_g <= 0; m_b <= 0;
      m_y <= 0; m_u <= 0; m_v <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_cnt == 0) begin
        if (start) begin
          m_cnt <= 1;
          m_y <= int'(y_in);
          m_u <= int'($signed(u_in));
          m_v <= int'($signed(v_in));
        end
      end else if (m_cnt == 5) begin
        m_cnt  <= 0;
        m_done <= 1'b1;
        m_r <= clamp(m_y + term(m_v, 359));
        m_g <= clamp(m_y - term(m_u, 88) - term(m_v, 183));
        m_b <= clamp(m_y + term(m_u, 454));
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("busy", int'(busy), int'(m_cnt != 0));
    check("done", int'(done), int'(m_done));
    check("r", int'(r_out), m_r);
    check("g", int'(g_out), m_g);
    check("b", int'(b_out), m_b);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input int y, input int u, input int v);
    y_in = 8'(y);
    u_in = 9'(u);
    v_in = 9'(v);
  endtask

  // One conversion with literal expectations; inputs are scrambled after the start edge.
  task automatic run_px(input int y, input int u, input int v,
                        input int er, input int eg, input int eb);
    int k;
    start = 1'b1;
    set_vec(y, u, v);
    tick();
    start = 1'b0;
    y_in = 8'($urandom);
    u_in = 9'($urandom);
    v_in = 9'($urandom);
    k = 0;
    while (k < 20 && !done) begin
      tick();
      k++;
    end
    check("latency", k, 5);
    check("lit_r", int'(r_out), er);
    check("lit_g", int'(g_out), eg);
    check("lit_b", int'(b_out), eb);
    tick();
    check("done_width", int'(done), 0);
  endtask

  initial begin
    int pulses;
    repeat (3) tick();
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_rgb", int'({r_out, g_out, b_out}), 0);
    rst_n = 1'b1;
    tick();

    // T1..T4 directed vectors
    run_px(128, 0, 0, 128, 128, 128);
    run_px(255, 0, 127, 255, 164, 255);
    run_px(0, -128, -128, 0, 135, 0);
    run_px(100, 50, -20, 72, 97, 189);
    repeat (2) tick();

    // T5 start held high: back-to-back conversions
    start = 1'b1;
    set_vec(128, 0, 0);
    tick();
    set_vec(100, 50, -20);
    for (int i = 1; i < 20; i++) begin
      tick();
      check("t5_done_pos", int'(done), int'(i == 5 || i == 11 || i == 17));
      if (i == 5) check("t5_r1", int'(r_out), 128);
      if (i == 11) begin
        check("t5_r2", int'(r_out), 72);
        check("t5_g2", int'(g_out), 97);
        check("t5_b2", int'(b_out), 189);
      end
    end
    start = 1'b0;
    repeat (8) tick();

    // Start pulses during busy are ignored
    pulses = 0;
    set_vec(255, 0, 127);
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (i == 1 || i == 3) start = 1'b1;
      else start = 1'b0;
      tick();
      if (done) pulses++;
    end
    start = 1'b0;
    check("t5_single_done", pulses, 1);
    repeat (8) tick();

    // T6 reset mid-conversion
    start = 1'b1;
    set_vec(100, 50, -20);
    tick();
    start = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    check("t6_busy", int'(busy), 0);
    check("t6_done", int'(done), 0);
    check("t6_rgb", int'({r_out, g_out, b_out}), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done) pulses++;
    end
    check("t6_no_done", pulses, 0);
    run_px(128, 0, 0, 128, 128, 128);
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
